// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer between NUM_REQ byte producers.
// Each requester owns a one-byte holding slot that frees only when its frame has left the line.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int GAP_CLKS     = 0,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                 i_Clk,
    input  logic                 i_reset_n,
    input  logic [NUM_REQ-1:0]   i_req_valid,
    input  logic [8*NUM_REQ-1:0] i_req_data,
    output logic [NUM_REQ-1:0]   o_req_ready,
    output logic [7:0]           o_tx_data,
    output logic                 o_tx_start,
    input  logic                 i_tx_busy,
    input  logic                 i_tx_done,
    output logic [NUM_REQ-1:0]   o_grant,
    output logic                 o_active,
    output logic                 o_err
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int CNT_MAX = (BUSY_TIMEOUT > GAP_CLKS) ? BUSY_TIMEOUT : GAP_CLKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1) + 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_GAP       = 3'd4;

    logic [2:0]         state;
    logic [NUM_REQ-1:0] pending;
    logic [7:0]         slot [NUM_REQ];
    logic [IDX_W-1:0]   rr;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   owner_next;
    logic [CNT_W-1:0]   cnt;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [NUM_REQ-1:0] accept;
    logic [NUM_REQ-1:0] clr_mask;
    logic               timeout_hit;
    logic               frame_end;

    assign o_req_ready = ~pending;
    assign o_active    = (state != S_IDLE);
    assign accept      = i_req_valid & ~pending;
    assign timeout_hit = (cnt == CNT_W'(BUSY_TIMEOUT - 1));
    assign frame_end   = ((state == S_WAIT_BUSY) && !i_tx_busy && timeout_hit) ||
                         ((state == S_WAIT_DONE) && (i_tx_done || !i_tx_busy));
    assign clr_mask    = frame_end ? o_grant : '0;
    assign owner_next  = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

    // First pending slot at or after rr, wrapping around.
    always_comb begin
        int j;
        pick_valid  = 1'b0;
        pick_idx    = '0;
        pick_onehot = '0;
        j           = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(rr) + i) % NUM_REQ;
            if (!pick_valid && pending[j]) begin
                pick_valid     = 1'b1;
                pick_idx       = IDX_W'(j);
                pick_onehot[j] = 1'b1;
            end
        end
    end

    // Accept and release never collide on one bit: a pending slot is not ready.
    always_ff @(posedge i_Clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pending <= '0;
            for (int k = 0; k < NUM_REQ; k++) begin
                slot[k] <= 8'h00;
            end
        end else begin
            pending <= (pending & ~clr_mask) | accept;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (accept[k]) begin
                    slot[k] <= i_req_data[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= S_IDLE;
            rr         <= '0;
            owner      <= '0;
            cnt        <= '0;
            o_grant    <= '0;
            o_tx_data  <= 8'h00;
            o_tx_start <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            o_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        o_grant    <= pick_onehot;
                        owner      <= pick_idx;
                        o_tx_data  <= slot[pick_idx];
                        o_tx_start <= 1'b1;
                        state      <= S_START;
                    end
                end
                S_START: begin
                    o_tx_start <= 1'b0;
                    cnt        <= '0;
                    state      <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (i_tx_busy) begin
                        state <= S_WAIT_DONE;
                    end else if (timeout_hit) begin
                        // Serializer never acknowledged: drop the byte and move on.
                        o_err   <= 1'b1;
                        o_grant <= '0;
                        rr      <= owner_next;
                        cnt     <= '0;
                        state   <= S_GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (i_tx_done || !i_tx_busy) begin
                        o_grant <= '0;
                        rr      <= owner_next;
                        cnt     <= '0;
                        state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (cnt == CNT_W'(GAP_CLKS)) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small behavioural serializer whose
// busy/done ordering can be switched per test.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int GAP_CLKS     = 10;
    localparam int BUSY_TIMEOUT = 15;
    localparam int FRAME        = 8;

    localparam logic [1:0] MODE_NORMAL     = 2'd0;
    localparam logic [1:0] MODE_BUSY_FIRST = 2'd1;
    localparam logic [1:0] MODE_DONE_FIRST = 2'd2;
    localparam logic [1:0] MODE_DEAD       = 2'd3;

    logic                   i_Clk = 1'b0;
    logic                   i_reset_n;
    logic [NUM_REQ-1:0]     i_req_valid;
    logic [8*NUM_REQ-1:0]   i_req_data;
    logic [NUM_REQ-1:0]     o_req_ready;
    logic [7:0]             o_tx_data;
    logic                   o_tx_start;
    logic                   i_tx_busy;
    logic                   i_tx_done;
    logic [NUM_REQ-1:0]     o_grant;
    logic                   o_active;
    logic                   o_err;

    logic [1:0]  ser_mode;
    logic [3:0]  ser_cnt;
    logic [11:0] start_q [$];

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int         req;
        logic [7:0] data;
        logic [3:0] exp_grant;
        logic [1:0] mode;
    } vec_t;

    vec_t vecs [6];

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ),
        .GAP_CLKS(GAP_CLKS),
        .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) dut (
        .i_Clk(i_Clk),
        .i_reset_n(i_reset_n),
        .i_req_valid(i_req_valid),
        .i_req_data(i_req_data),
        .o_req_ready(o_req_ready),
        .o_tx_data(o_tx_data),
        .o_tx_start(o_tx_start),
        .i_tx_busy(i_tx_busy),
        .i_tx_done(i_tx_done),
        .o_grant(o_grant),
        .o_active(o_active),
        .o_err(o_err)
    );

    always #20 i_Clk = ~i_Clk;

    // Serializer model: busy rises on the edge that samples start; the tail
    // ordering of busy-fall and done-pulse depends on ser_mode.
    always @(posedge i_Clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            i_tx_busy <= 1'b0;
            i_tx_done <= 1'b0;
            ser_cnt   <= 4'd0;
        end else begin
            i_tx_done <= 1'b0;
            if (o_tx_start && ser_mode != MODE_DEAD) begin
                i_tx_busy <= 1'b1;
                ser_cnt   <= 4'(FRAME);
            end else if (ser_cnt != 4'd0) begin
                ser_cnt <= ser_cnt - 4'd1;
                case (ser_mode)
                    MODE_NORMAL: if (ser_cnt == 4'd1) begin
                        i_tx_busy <= 1'b0;
                        i_tx_done <= 1'b1;
                    end
                    MODE_BUSY_FIRST: begin
                        if (ser_cnt == 4'd2) i_tx_busy <= 1'b0;
                        else if (ser_cnt == 4'd1) i_tx_done <= 1'b1;
                    end
                    MODE_DONE_FIRST: begin
                        if (ser_cnt == 4'd2) i_tx_done <= 1'b1;
                        else if (ser_cnt == 4'd1) i_tx_busy <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge i_Clk) begin
        if (o_tx_start === 1'b1) start_q.push_back({o_grant, o_tx_data});
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_ready"},  o_req_ready, 4'hF);
        check_output({tag, "_start"},  o_tx_start, 0);
        check_output({tag, "_data"},   o_tx_data, 0);
        check_output({tag, "_grant"},  o_grant, 0);
        check_output({tag, "_active"}, o_active, 0);
        check_output({tag, "_err"},    o_err, 0);
    endtask

    task automatic do_reset();
        i_reset_n   = 1'b0;
        i_req_valid = '0;
        i_req_data  = '0;
        repeat (3) @(negedge i_Clk);
        i_reset_n = 1'b1;
        @(negedge i_Clk);
    endtask

    task automatic wait_starts(input int target, input string name);
        int i = 0;
        while (start_q.size() < target && i < 400) begin
            @(negedge i_Clk);
            i++;
        end
        check_output(name, start_q.size(), target);
    endtask

    task automatic wait_idle(input string name);
        int i = 0;
        while (o_active && i < 200) begin
            @(negedge i_Clk);
            i++;
        end
        check_output(name, o_active, 0);
    endtask

    task automatic check_start_entry(input int idx, input logic [11:0] exp, input string name);
        if (idx < start_q.size()) check_output(name, start_q[idx], exp);
        else check_output({name, "_missing"}, 0, 1);
    endtask

    // Single requester, full frame: acceptance, one-clock start, hold, release, gap length.
    task automatic apply_stimulus(input vec_t v);
        int   k;
        int   i;
        logic hold_ok;
        k = v.req;
        ser_mode = v.mode;
        i_req_data[8*k +: 8] = v.data;
        i_req_valid[k] = 1'b1;
        @(negedge i_Clk);
        check_output("accept_ready", o_req_ready[k], 0);
        check_output("accept_nostart", o_tx_start, 0);
        i_req_valid[k] = 1'b0;
        @(negedge i_Clk);
        check_output("start_high", o_tx_start, 1);
        check_output("start_data", o_tx_data, v.data);
        check_output("start_grant", o_grant, v.exp_grant);
        check_output("start_active", o_active, 1);
        @(negedge i_Clk);
        check_output("start_width", o_tx_start, 0);
        hold_ok = 1'b1;
        i = 0;
        while (!o_req_ready[k] && i < 200) begin
            if (o_tx_data !== v.data || o_grant !== v.exp_grant) hold_ok = 1'b0;
            @(negedge i_Clk);
            i++;
        end
        check_output("release_ready", o_req_ready[k], 1);
        check_output("frame_hold", hold_ok, 1);
        check_output("gap_grant", o_grant, 0);
        check_output("gap_active", o_active, 1);
        i = 0;
        while (o_active && i < 50) begin
            @(negedge i_Clk);
            i++;
        end
        check_output("gap_len", i, GAP_CLKS + 1);
    endtask

    // All four load on one edge, requester 0 reloads as soon as its slot frees.
    task automatic run_rr(input logic [1:0] mode);
        int i;
        int base;
        logic [11:0] exp_order [5];
        exp_order[0] = 12'h110;
        exp_order[1] = 12'h211;
        exp_order[2] = 12'h412;
        exp_order[3] = 12'h813;
        exp_order[4] = 12'h120;
        do_reset();
        ser_mode = mode;
        base = start_q.size();
        i_req_data  = 32'h13121110;
        i_req_valid = 4'hF;
        @(negedge i_Clk);
        i_req_valid = 4'b0001;
        i_req_data[7:0] = 8'h20;
        i = 0;
        while (!o_req_ready[0] && i < 400) begin
            @(negedge i_Clk);
            i++;
        end
        check_output("rr_reload_ready", o_req_ready[0], 1);
        @(negedge i_Clk);
        i_req_valid = '0;
        wait_starts(base + 5, "rr_start_count");
        for (int j = 0; j < 5; j++) check_start_entry(base + j, exp_order[j], "rr_order");
        wait_idle("rr_idle");
        check_output("rr_all_ready", o_req_ready, 4'hF);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int i;
        int base;

        vecs[0] = '{0, 8'h5A, 4'b0001, MODE_NORMAL};
        vecs[1] = '{2, 8'hA5, 4'b0100, MODE_BUSY_FIRST};
        vecs[2] = '{3, 8'hFF, 4'b1000, MODE_DONE_FIRST};
        vecs[3] = '{1, 8'h00, 4'b0010, MODE_NORMAL};
        vecs[4] = '{1, 8'h3C, 4'b0010, MODE_BUSY_FIRST};
        vecs[5] = '{0, 8'h81, 4'b0001, MODE_DONE_FIRST};

        ser_mode    = MODE_NORMAL;
        i_reset_n   = 1'b0;
        i_req_valid = '0;
        i_req_data  = '0;
        @(negedge i_Clk);
        check_reset_outputs("por");
        @(negedge i_Clk);
        i_reset_n = 1'b1;
        @(negedge i_Clk);

        for (int v = 0; v < 6; v++) apply_stimulus(vecs[v]);

        // rr now points at 1: requesters 0 and 3 together go 3 first, then 0.
        ser_mode = MODE_NORMAL;
        base = start_q.size();
        i_req_data  = 32'hC30000C0;
        i_req_valid = 4'b1001;
        @(negedge i_Clk);
        i_req_valid = '0;
        wait_starts(base + 2, "wrap_start_count");
        check_start_entry(base,     12'h8C3, "wrap_first");
        check_start_entry(base + 1, 12'h1C0, "wrap_second");

        run_rr(MODE_DONE_FIRST);
        run_rr(MODE_BUSY_FIRST);

        // Gap: done of frame 1 to start of frame 2 is GAP_CLKS + 3 clocks.
        do_reset();
        ser_mode = MODE_NORMAL;
        i_req_data  = 32'h00005544;
        i_req_valid = 4'b0011;
        @(negedge i_Clk);
        i_req_valid = '0;
        i = 0;
        while (!i_tx_done && i < 100) begin
            @(negedge i_Clk);
            i++;
        end
        check_output("gap_done_seen", i_tx_done, 1);
        i = 0;
        do begin
            @(negedge i_Clk);
            i++;
        end while (!o_tx_start && i < 100);
        check_output("gap_spacing", i, GAP_CLKS + 3);
        check_output("gap_second_data", o_tx_data, 8'h55);
        check_output("gap_second_grant", o_grant, 4'b0010);
        wait_idle("gap_idle");

        // Timeout: serializer never raises busy.
        do_reset();
        ser_mode = MODE_DEAD;
        i_req_data  = 32'h88770000;
        i_req_valid = 4'b1100;
        @(negedge i_Clk);
        i_req_valid = '0;
        @(negedge i_Clk);
        check_output("to_start", o_tx_start, 1);
        check_output("to_grant", o_grant, 4'b0100);
        check_output("to_data", o_tx_data, 8'h77);
        i = 0;
        while (!o_err && i < 40) begin
            @(negedge i_Clk);
            i++;
        end
        check_output("to_err_delay", i, BUSY_TIMEOUT + 1);
        check_output("to_slot_free", o_req_ready, 4'b0111);
        check_output("to_grant_clear", o_grant, 0);
        ser_mode = MODE_NORMAL;
        @(negedge i_Clk);
        check_output("to_err_width", o_err, 0);
        i = 0;
        while (!o_tx_start && i < 40) begin
            @(negedge i_Clk);
            i++;
        end
        check_output("to_next_start", o_tx_start, 1);
        check_output("to_next_grant", o_grant, 4'b1000);
        check_output("to_next_data", o_tx_data, 8'h88);
        wait_idle("to_next_idle");
        check_output("to_next_ready", o_req_ready, 4'hF);

        // Reset mid-frame: requester 1 owns the line, slot 2 pending.
        do_reset();
        ser_mode = MODE_NORMAL;
        i_req_data  = 32'h00323100;
        i_req_valid = 4'b0010;
        @(negedge i_Clk);
        i_req_valid = '0;
        @(negedge i_Clk);
        check_output("mid_grant", o_grant, 4'b0010);
        i_req_valid = 4'b0100;
        @(negedge i_Clk);
        i_req_valid = '0;
        check_output("mid_pending2", o_req_ready, 4'b1001);
        repeat (2) @(negedge i_Clk);
        check_output("mid_active", o_active, 1);
        #7 i_reset_n = 1'b0;
        #1 check_reset_outputs("mid_async");
        @(negedge i_Clk);
        check_reset_outputs("mid_held");
        i_reset_n = 1'b1;
        base = start_q.size();
        repeat (30) @(negedge i_Clk);
        check_output("post_reset_nostart", start_q.size(), base);
        check_output("post_reset_ready", o_req_ready, 4'hF);
        check_output("post_reset_active", o_active, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
